// File: rtl/scaler_div_fix_pipe.sv
// Two-stage streaming down-scaler: divides signed samples by 2**$clog2(SCALE), sign-magnitude, round half away from zero.
// Optional macro SCALER_DIV_FIX_TRUNC_EN selects truncation toward zero instead of rounding.
module scaler_div_fix_pipe #(
    parameter int WIDTH = 16,
    parameter int SCALE = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_uf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] uf_count
);
    localparam int SHAMT = $clog2(SCALE);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [WIDTH-1:0] s1_mag_reg;
    logic             s1_nz_reg;
    logic             s1_last_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic             out_uf_reg;
    logic [CNT_W-1:0] uf_count_reg;

    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] in_mag;
    logic [WIDTH:0]   mag_ext;
    logic [WIDTH:0]   rmag;
    logic [WIDTH-1:0] out_data_next;
    logic             out_uf_next;
    logic             out_hs;
    logic             cnt_inc;

    // S2 refills whenever it is empty, so bubbles never block the pipe
    assign s2_en    = out_ready || !out_valid_reg;
    assign s1_en    = s2_en || !s1_valid_reg;
    assign in_ready = s1_en || !rst_n;

    // Most negative value is clamped so the magnitude range is symmetric
    always_comb begin
        in_mag = in_data;
        if (in_data[WIDTH-1]) begin
            if (in_data == MIN_VAL) begin
                in_mag = MAX_VAL;
            end else begin
                in_mag = ~in_data + 1'b1;
            end
        end
    end

    assign mag_ext = {1'b0, s1_mag_reg};

    generate
        if (SHAMT == 0) begin : g_pass
            assign rmag = mag_ext;
        end else if (SHAMT >= WIDTH) begin : g_zero
            assign rmag = '0;
        end else begin : g_shift
`ifdef SCALER_DIV_FIX_TRUNC_EN
            assign rmag = mag_ext >> SHAMT;
`else
            localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (SHAMT - 1);
            assign rmag = (mag_ext + HALF) >> SHAMT;
`endif
        end
    endgenerate

    // A zero magnitude negates to zero, so the result is always +0
    assign out_data_next = s1_sign_reg ? (~rmag[WIDTH-1:0] + 1'b1) : rmag[WIDTH-1:0];
    assign out_uf_next   = s1_nz_reg && (rmag == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s1_nz_reg    <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else if (s1_en) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= in_data[WIDTH-1];
                s1_mag_reg  <= in_mag;
                s1_nz_reg   <= (in_data != '0);
                s1_last_reg <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_uf_reg    <= 1'b0;
        end else if (s2_en) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg <= out_data_next;
                out_last_reg <= s1_last_reg;
                out_uf_reg   <= out_uf_next;
            end
        end
    end

    assign out_hs  = out_valid_reg && out_ready;
    assign cnt_inc = out_hs && out_uf_reg;

    // Clear wins over the old value but still counts a coincident underflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_count_reg <= '0;
        end else if (clr_cnt) begin
            uf_count_reg <= cnt_inc ? CNT_W'(1) : '0;
        end else if (cnt_inc && (uf_count_reg != CNT_MAX)) begin
            uf_count_reg <= uf_count_reg + 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_uf    = out_uf_reg;
    assign uf_count  = uf_count_reg;
endmodule
